m68k_bus_responder: RTL and testbench
=====================================

Name: m68k_bus_responder

Overview:
- Slave/target end of the 68000 asynchronous bus that m68kcpu drives.
- Decodes AS/UDS/LDS/RW/ADDRESS for one address window and forwards the cycle to a back-end register interface with a req/ack handshake.
- Returns read data, terminates the cycle with DTACK after a programmable number of wait states, and signals BERR on back-end timeout.
- Sits beside other bus targets on the shared bus; all bus inputs are synchronous to MCLK.

Parameters:
- BASE_ADDR, 23'h000000, window base (compared on ADDRESS[23:1]).
- ADDR_MASK, 23'h7FFF00, bits of ADDRESS compared against BASE_ADDR.
- WAIT_STATES, 0, minimum MCLK edges from request issue to DTACK assertion (0..15).
- TIMEOUT, 64, MCLK edges in REQ without ack before BERR (2..255).

Ports:
- MCLK  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; forces idle state.
- AS  in  1  address strobe, active low.
- UDS  in  1  upper data strobe, active low.
- LDS  in  1  lower data strobe, active low.
- RW  in  1  1 = read, 0 = write.
- ADDRESS  in  23  word address [23:1].
- DATA_IN  in  16  bus write data.
- DATA_OUT  out  16  bus read data.
- DATA_OE  out  1  drive DATA_OUT onto bus.
- DTACK  out  1  data acknowledge, active low.
- BERR  out  1  bus error, active low.
- req  out  1  back-end request (level).
- req_we  out  1  1 = write.
- req_addr  out  23  latched word address.
- req_be  out  2  byte enables {upper, lower}.
- req_wdata  out  16  latched write data.
- ack  in  1  back-end completion, single-cycle pulse; ignored while req = 0.
- ack_rdata  in  16  read data, valid with ack.

Behaviour:
- Reset (async, immediate): DTACK=1, BERR=1, DATA_OE=0, DATA_OUT=0, req=0, req_we=0, req_addr=0, req_be=0, req_wdata=0, cnt=0, state=IDLE. Reset asserted mid-cycle abandons the cycle; no DTACK/BERR is produced.
- sel = ~AS & ((ADDRESS & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) & (~UDS | ~LDS).
  - A write whose strobes lag AS is simply not selected until a strobe is low.
- States: IDLE, REQ, WAIT, ACK, ERR, ABORT.
- IDLE, edge with sel:
  - Go to REQ; req=1; latch req_we=~RW, req_addr=ADDRESS, req_be={~UDS,~LDS}, req_wdata=DATA_IN; cnt=0.
- REQ, each edge: cnt increments (saturating 8 bits). Priority within one edge:
  - ack sampled: req=0, capture DATA_OUT=ack_rdata if read. Then:
    - cnt >= WAIT_STATES (value before increment): go to ACK, DTACK=0, DATA_OE=~req_we.
    - otherwise: go to WAIT.
  - else AS high (initiator abort): go to ABORT.
  - else cnt == TIMEOUT-1: go to ERR, BERR=0.
- WAIT: cnt increments; when cnt >= WAIT_STATES, go to ACK, DTACK=0, DATA_OE=~req_we. AS high in WAIT goes straight to IDLE with no DTACK.
- ACK: hold DTACK=0 and DATA_OE until AS sampled high. On that edge: DTACK=1, DATA_OE=0, go to IDLE.
  - Back-to-back cycles need AS to be seen high for at least one edge.
- ERR: BERR held low; req stays 1 until ack. When AS sampled high and req=0: BERR=1, go to IDLE. A late ack's data is discarded.
- ABORT: req stays 1 (requests are never retracted). When ack is sampled: req=0, go to IDLE. No DTACK or DATA_OE.
- Latency: DTACK falls at edge max(ack edge, E0+WAIT_STATES+1), where E0 is the select edge. Minimum is 1 edge after the request edge.
- ADDRESS/DATA changes after the select edge are ignored; the latched copies are used.
- Simultaneous ack and timeout edge: ack wins.

Decomposition:
- Shared package m68k_bus_pkg holds:
  - state enum (IDLE, REQ, WAIT, ACK, ERR, ABORT);
  - constants BUS_ASSERT=1'b0 and BUS_NEGATE=1'b1;
  - address width constant 23.
- No sub-module; a single flat FSM plus counter.

Test Plan:
- Word read, WAIT_STATES=0, ADDRESS=BASE, AS/UDS/LDS=0 at E0, ack at E1 with rdata 16'hBEEF -> DTACK=0, DATA_OE=1, DATA_OUT=16'hBEEF after E1; AS high at E5 -> DTACK=1, DATA_OE=0 after E5.
- Byte write, WAIT_STATES=3, LDS=0, UDS=1, DATA_IN=16'h00A5, ack at E1 -> req_be=2'b01, req_wdata=16'h00A5, req_we=1; DTACK=0 first after E4; DATA_OE stays 0.
- Out-of-window access, ADDRESS=BASE^23'h000100 -> req, DTACK and BERR stay inactive for 20 cycles.
- Timeout, TIMEOUT=8, no ack -> BERR=0 after E8 with req still 1; ack at E12 and AS high at E13 -> BERR=1 after E13, state IDLE.
- Abort: AS rises at E2 before ack, ack arrives at E5 -> req=0 after E5; DTACK never asserted; a new select at E6 is accepted.
- Reset asserted while in ACK -> DTACK=1 and DATA_OE=0 immediately (asynchronously); after release, the next select behaves as in the first scenario.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus target.
//   state_t     : responder FSM states
//   BUS_ASSERT  : level of an asserted active-low bus signal
//   BUS_NEGATE  : level of a negated active-low bus signal
//   ADDR_W      : word address width (ADDRESS[23:1])
package m68k_bus_pkg;

  localparam int   ADDR_W     = 23;
  localparam logic BUS_ASSERT = 1'b0;
  localparam logic BUS_NEGATE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ACK,
    ERR,
    ABORT
  } state_t;

endpackage

// File: rtl/m68k_bus_responder.sv
// Target end of the 68000 asynchronous bus. Decodes one address window,
// forwards the cycle to a back-end register port through a req/ack
// handshake, returns read data and terminates with DTACK after a minimum
// number of wait states, or with BERR when the back end does not answer.
//
// Ports:
//   MCLK, reset          clock, asynchronous active-high reset
//   AS, UDS, LDS, RW     68000 bus control (strobes active low, RW 1=read)
//   ADDRESS, DATA_IN     word address [23:1], write data from the bus
//   DATA_OUT, DATA_OE    read data and its bus-drive enable
//   DTACK, BERR          cycle termination, active low
//   req .. req_wdata     back-end request (level) and latched cycle info
//   ack, ack_rdata       back-end completion pulse and read data
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 23'h000000,
  parameter logic [ADDR_W-1:0] ADDR_MASK   = 23'h7FFF00,
  parameter int                WAIT_STATES = 0,
  parameter int                TIMEOUT     = 64
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              AS,
  input  logic              UDS,
  input  logic              LDS,
  input  logic              RW,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [15:0]       DATA_IN,
  output logic [15:0]       DATA_OUT,
  output logic              DATA_OE,
  output logic              DTACK,
  output logic              BERR,
  output logic              req,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [1:0]        req_be,
  output logic [15:0]       req_wdata,
  input  logic              ack,
  input  logic [15:0]       ack_rdata
);

  localparam logic [7:0] WS_C     = 8'(WAIT_STATES);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t              state, nxt_state;
  logic [7:0]          cnt, nxt_cnt, cnt_inc;
  logic [15:0]         nxt_dout, nxt_wdata;
  logic                nxt_oe, nxt_dtack, nxt_berr, nxt_req, nxt_we;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [1:0]          nxt_be;
  logic                sel;

  // A cycle is ours only once a data strobe is low; a write whose strobes
  // trail AS is picked up on the first edge where one is asserted.
  assign sel = ~AS & ((ADDRESS & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) & (~UDS | ~LDS);

  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_dout  = DATA_OUT;
    nxt_oe    = DATA_OE;
    nxt_dtack = DTACK;
    nxt_berr  = BERR;
    nxt_req   = req;
    nxt_we    = req_we;
    nxt_addr  = req_addr;
    nxt_be    = req_be;
    nxt_wdata = req_wdata;
    case (state)
      IDLE: begin
        if (sel) begin
          nxt_state = REQ;
          nxt_req   = 1'b1;
          nxt_we    = ~RW;
          nxt_addr  = ADDRESS;
          nxt_be    = {~UDS, ~LDS};
          nxt_wdata = DATA_IN;
          nxt_cnt   = 8'd0;
        end
      end
      REQ: begin
        nxt_cnt = cnt_inc;
        // ack beats both abort and timeout on the same edge
        if (ack) begin
          nxt_req = 1'b0;
          if (!req_we) nxt_dout = ack_rdata;
          if (cnt >= WS_C) begin
            nxt_state = ACK;
            nxt_dtack = BUS_ASSERT;
            nxt_oe    = ~req_we;
          end else begin
            nxt_state = WAIT;
          end
        end else if (AS) begin
          nxt_state = ABORT;
        end else if (cnt == TO_LAST) begin
          nxt_state = ERR;
          nxt_berr  = BUS_ASSERT;
        end
      end
      WAIT: begin
        if (AS) begin
          nxt_state = IDLE;
        end else begin
          nxt_cnt = cnt_inc;
          if (cnt >= WS_C) begin
            nxt_state = ACK;
            nxt_dtack = BUS_ASSERT;
            nxt_oe    = ~req_we;
          end
        end
      end
      ACK: begin
        if (AS) begin
          nxt_state = IDLE;
          nxt_dtack = BUS_NEGATE;
          nxt_oe    = 1'b0;
        end
      end
      ERR: begin
        // The request stays up until the back end answers; its data is dropped.
        if (ack && req) nxt_req = 1'b0;
        if (AS && !req) begin
          nxt_state = IDLE;
          nxt_berr  = BUS_NEGATE;
        end
      end
      ABORT: begin
        if (ack) begin
          nxt_req   = 1'b0;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt_state;
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      cnt       <= 8'd0;
      DATA_OUT  <= 16'd0;
      DATA_OE   <= 1'b0;
      DTACK     <= BUS_NEGATE;
      BERR      <= BUS_NEGATE;
      req       <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_be    <= 2'b00;
      req_wdata <= 16'd0;
    end else begin
      cnt       <= nxt_cnt;
      DATA_OUT  <= nxt_dout;
      DATA_OE   <= nxt_oe;
      DTACK     <= nxt_dtack;
      BERR      <= nxt_berr;
      req       <= nxt_req;
      req_we    <= nxt_we;
      req_addr  <= nxt_addr;
      req_be    <= nxt_be;
      req_wdata <= nxt_wdata;
    end
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: one instance with no wait states,
// one with three; both with an 8-edge back-end timeout.
module tb_m68k_bus_responder;
  import m68k_bus_pkg::*;

  logic        MCLK = 1'b0;
  logic        rst;
  logic        as_n, uds_n, lds_n, rw;
  logic [22:0] addr;
  logic [15:0] din, rdata;
  logic        ack0, ack3;

  logic [15:0] dout0, dout3, wdata0, wdata3;
  logic        oe0, oe3, dtack0, dtack3, berr0, berr3;
  logic        req0, req3, we0, we3;
  logic [22:0] raddr0, raddr3;
  logic [1:0]  be0, be3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 MCLK = ~MCLK;

  m68k_bus_responder #(.WAIT_STATES(0), .TIMEOUT(8)) u_dut0 (
    .MCLK(MCLK), .reset(rst), .AS(as_n), .UDS(uds_n), .LDS(lds_n), .RW(rw),
    .ADDRESS(addr), .DATA_IN(din), .DATA_OUT(dout0), .DATA_OE(oe0),
    .DTACK(dtack0), .BERR(berr0), .req(req0), .req_we(we0), .req_addr(raddr0),
    .req_be(be0), .req_wdata(wdata0), .ack(ack0), .ack_rdata(rdata)
  );

  m68k_bus_responder #(.WAIT_STATES(3), .TIMEOUT(8)) u_dut3 (
    .MCLK(MCLK), .reset(rst), .AS(as_n), .UDS(uds_n), .LDS(lds_n), .RW(rw),
    .ADDRESS(addr), .DATA_IN(din), .DATA_OUT(dout3), .DATA_OE(oe3),
    .DTACK(dtack3), .BERR(berr3), .req(req3), .req_we(we3), .req_addr(raddr3),
    .req_be(be3), .req_wdata(wdata3), .ack(ack3), .ack_rdata(rdata)
  );

  typedef struct {
    logic        as_n, uds_n, lds_n, rw;
    logic [22:0] addr;
    logic        ack;
    logic [15:0] rdata;
    logic        dtack, berr, oe, req;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic a, u, l, r, input logic [22:0] ad,
                              input logic k, input logic [15:0] rd,
                              input logic dt, be, oe, rq, input logic [15:0] dq);
    vec_t v;
    v.as_n = a; v.uds_n = u; v.lds_n = l; v.rw = r; v.addr = ad;
    v.ack = k; v.rdata = rd;
    v.dtack = dt; v.berr = be; v.oe = oe; v.req = rq; v.dout = dq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic bus_idle();
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    addr = 23'd0; din = 16'd0; ack0 = 1'b0; ack3 = 1'b0; rdata = 16'd0;
  endtask

  task automatic do_reset();
    bus_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      as_n = tbl[i].as_n; uds_n = tbl[i].uds_n; lds_n = tbl[i].lds_n;
      rw = tbl[i].rw; addr = tbl[i].addr; ack0 = tbl[i].ack; rdata = tbl[i].rdata;
      step();
      chk($sformatf("%s[%0d].DTACK", tag, i), 32'(dtack0), 32'(tbl[i].dtack));
      chk($sformatf("%s[%0d].BERR", tag, i), 32'(berr0), 32'(tbl[i].berr));
      chk($sformatf("%s[%0d].DATA_OE", tag, i), 32'(oe0), 32'(tbl[i].oe));
      chk($sformatf("%s[%0d].req", tag, i), 32'(req0), 32'(tbl[i].req));
      chk($sformatf("%s[%0d].DATA_OUT", tag, i), 32'(dout0), 32'(tbl[i].dout));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Word read, no wait states: select E0, ack E1, AS released at E5.
    // The address changes at E1 to an out-of-window value and must be ignored.
    //          AS UDS LDS RW addr         ack rdata     DT BE OE RQ dout
    tbl.push_back(mk(0, 0, 0, 1, 23'h000000, 0, 16'h0000, 1, 1, 0, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 1, 23'h000155, 1, 16'hBEEF, 0, 1, 1, 0, 16'hBEEF));
    tbl.push_back(mk(0, 0, 0, 1, 23'h000155, 0, 16'h1234, 0, 1, 1, 0, 16'hBEEF));
    tbl.push_back(mk(0, 0, 0, 1, 23'h000000, 0, 16'h1234, 0, 1, 1, 0, 16'hBEEF));
    tbl.push_back(mk(0, 0, 0, 1, 23'h000000, 0, 16'h0000, 0, 1, 1, 0, 16'hBEEF));
    tbl.push_back(mk(1, 1, 1, 1, 23'h000000, 0, 16'h0000, 1, 1, 0, 0, 16'hBEEF));
    tbl.push_back(mk(1, 1, 1, 1, 23'h000000, 0, 16'h0000, 1, 1, 0, 0, 16'hBEEF));

    // Reset state
    bus_idle();
    rst = 1'b1;
    #2;
    step();
    chk("rst.DTACK", 32'(dtack0), 32'd1);
    chk("rst.BERR", 32'(berr0), 32'd1);
    chk("rst.DATA_OE", 32'(oe0), 32'd0);
    chk("rst.DATA_OUT", 32'(dout0), 32'd0);
    chk("rst.req", 32'(req0), 32'd0);
    chk("rst.req_we", 32'(we0), 32'd0);
    chk("rst.req_addr", 32'(raddr0), 32'd0);
    chk("rst.req_be", 32'(be0), 32'd0);
    chk("rst.req_wdata", 32'(wdata0), 32'd0);
    rst = 1'b0;
    step();

    // Scenario 1: word read
    run_table("read");

    // Scenario 2: byte write, three wait states, ack at E1 -> DTACK after E4
    do_reset();
    as_n = 0; uds_n = 1; lds_n = 0; rw = 0; addr = 23'h00003C; din = 16'h00A5;
    step();                                             // E0
    chk("bw.req", 32'(req3), 32'd1);
    chk("bw.req_be", 32'(be3), 32'b01);
    chk("bw.req_we", 32'(we3), 32'd1);
    chk("bw.req_wdata", 32'(wdata3), 32'h00A5);
    chk("bw.req_addr", 32'(raddr3), 32'h3C);
    addr = 23'h00007F; din = 16'hFFFF; ack3 = 1;
    step();                                             // E1
    chk("bw.E1.req", 32'(req3), 32'd0);
    chk("bw.E1.DTACK", 32'(dtack3), 32'd1);
    ack3 = 0;
    step();                                             // E2
    chk("bw.E2.DTACK", 32'(dtack3), 32'd1);
    step();                                             // E3
    chk("bw.E3.DTACK", 32'(dtack3), 32'd1);
    step();                                             // E4
    chk("bw.E4.DTACK", 32'(dtack3), 32'd0);
    chk("bw.E4.DATA_OE", 32'(oe3), 32'd0);
    chk("bw.E4.BERR", 32'(berr3), 32'd1);
    chk("bw.hold.req_wdata", 32'(wdata3), 32'h00A5);
    chk("bw.hold.req_addr", 32'(raddr3), 32'h3C);
    as_n = 1; uds_n = 1; lds_n = 1;
    step();
    chk("bw.end.DTACK", 32'(dtack3), 32'd1);

    // Scenario 3: out-of-window access is never selected
    do_reset();
    as_n = 0; uds_n = 0; lds_n = 0; rw = 1; addr = 23'h000100;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("oow[%0d].req", i), 32'(req0), 32'd0);
      chk($sformatf("oow[%0d].DTACK", i), 32'(dtack0), 32'd1);
      chk($sformatf("oow[%0d].BERR", i), 32'(berr0), 32'd1);
    end

    // Scenario 4: timeout after 8 edges, late ack at E12, AS high at E13
    do_reset();
    as_n = 0; uds_n = 0; lds_n = 0; rw = 1; addr = 23'h000010;
    step();                                             // E0
    for (int e = 1; e <= 7; e++) begin
      step();
      chk($sformatf("to.E%0d.BERR", e), 32'(berr0), 32'd1);
    end
    step();                                             // E8
    chk("to.E8.BERR", 32'(berr0), 32'd0);
    chk("to.E8.req", 32'(req0), 32'd1);
    chk("to.E8.DTACK", 32'(dtack0), 32'd1);
    for (int e = 9; e <= 11; e++) step();
    chk("to.E11.BERR", 32'(berr0), 32'd0);
    ack0 = 1; rdata = 16'hDEAD;
    step();                                             // E12
    chk("to.E12.req", 32'(req0), 32'd0);
    chk("to.E12.BERR", 32'(berr0), 32'd0);
    chk("to.E12.DATA_OUT", 32'(dout0), 32'd0);
    ack0 = 0; as_n = 1; uds_n = 1; lds_n = 1;
    step();                                             // E13
    chk("to.E13.BERR", 32'(berr0), 32'd1);
    chk("to.E13.state", 32'(u_dut0.state), 32'(IDLE));
    chk("to.E13.DTACK", 32'(dtack0), 32'd1);

    // Scenario 5: abort before ack, ack at E5, new select at E6
    do_reset();
    as_n = 0; uds_n = 0; lds_n = 0; rw = 1; addr = 23'h000000;
    step();                                             // E0
    step();                                             // E1
    as_n = 1; uds_n = 1; lds_n = 1;
    step();                                             // E2
    chk("ab.E2.req", 32'(req0), 32'd1);
    step(); step();                                     // E3, E4
    chk("ab.E4.req", 32'(req0), 32'd1);
    chk("ab.E4.DTACK", 32'(dtack0), 32'd1);
    ack0 = 1; rdata = 16'h1111;
    step();                                             // E5
    chk("ab.E5.req", 32'(req0), 32'd0);
    chk("ab.E5.DTACK", 32'(dtack0), 32'd1);
    chk("ab.E5.DATA_OE", 32'(oe0), 32'd0);
    ack0 = 0; as_n = 0; uds_n = 0; lds_n = 0;
    step();                                             // E6
    chk("ab.E6.req", 32'(req0), 32'd1);
    ack0 = 1; rdata = 16'h5A5A;
    step();                                             // E7
    chk("ab.E7.DTACK", 32'(dtack0), 32'd0);
    chk("ab.E7.DATA_OUT", 32'(dout0), 32'h5A5A);
    ack0 = 0; as_n = 1; uds_n = 1; lds_n = 1;
    step(); step();

    // Scenario 6: asynchronous reset while in ACK, then a normal read
    do_reset();
    as_n = 0; uds_n = 0; lds_n = 0; rw = 1; addr = 23'h000000;
    step();
    ack0 = 1; rdata = 16'h7777;
    step();
    ack0 = 0;
    chk("rs.ack.DTACK", 32'(dtack0), 32'd0);
    rst = 1'b1;
    #1;
    chk("rs.async.DTACK", 32'(dtack0), 32'd1);
    chk("rs.async.DATA_OE", 32'(oe0), 32'd0);
    chk("rs.async.DATA_OUT", 32'(dout0), 32'd0);
    bus_idle();
    step();
    rst = 1'b0;
    step();
    chk("rs.idle.DTACK", 32'(dtack0), 32'd1);
    run_table("read2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
